// File: rtl/deinterleaver_pkg.sv
// Shared sizes and write-side state encoding for the block deinterleaver.
package deinterleaver_pkg;

    localparam logic [6:0] N_SIG  = 7'd48;
    localparam logic [6:0] N_DATA = 7'd96;
    localparam logic [6:0] COLS   = 7'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SIG  = 2'd1,
        DATA = 2'd2
    } wr_state_e;

endpackage

// File: rtl/deinterleaver_index_map.sv
// Read address for output bit k of an N-bit block: (N/16)*(k mod 16) + k/16.
module deint_index_map
    import deinterleaver_pkg::*;
(
    input  logic [6:0] n,
    input  logic [6:0] k,
    output logic [6:0] i
);

    // Largest value is 6*15+5 = 95, so 7 bits never overflow.
    always_comb begin
        i = ((n / COLS) * (k % COLS)) + (k / COLS);
    end

endmodule

// File: rtl/deinterleaver.sv
// Ping-pong block deinterleaver (48-bit SIGNAL, then 96-bit DATA blocks); drain starts one edge after the last bit.
// DEINT_BLOCK_FLAGS_EN adds out_sob / out_sig block markers.
module deinterleaver
    import deinterleaver_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic in_valid,
    input  logic sof,
    output logic out,
    output logic out_valid
`ifdef DEINT_BLOCK_FLAGS_EN
    ,
    output logic out_sob,
    output logic out_sig
`endif
);

    wr_state_e   state_q, state_d;
    logic [6:0]  wcnt_q, wcnt_d;
    logic        wsel_q, wsel_d;
    logic [95:0] buf0_q, buf0_d;
    logic [95:0] buf1_q, buf1_d;

    logic        rd_act_q, rd_act_d;
    logic [6:0]  rcnt_q, rcnt_d;
    logic        rd_sel_q, rd_sel_d;
    logic        rd_sig_q, rd_sig_d;
    logic        out_q, out_d;
    logic        out_valid_q, out_valid_d;

    logic        restart;
    logic        wr_en;
    logic        blk_done;
    logic [6:0]  wr_n;
    logic [6:0]  wr_addr;
    logic [6:0]  rd_n;
    logic [6:0]  rd_idx;
    logic        rd_bit;

    assign wr_n     = (state_q == SIG) ? N_SIG : N_DATA;
    assign restart  = in_valid & sof;
    assign wr_en    = in_valid & (sof | (state_q != IDLE));
    assign wr_addr  = sof ? 7'd0 : wcnt_q;
    // A sof bit always reopens SIGNAL, so it can never complete a block.
    assign blk_done = in_valid & ~sof & (state_q != IDLE) & (wcnt_q == (wr_n - 7'd1));

    assign rd_n   = rd_sig_q ? N_SIG : N_DATA;
    assign rd_bit = rd_sel_q ? buf1_q[rd_idx] : buf0_q[rd_idx];

    deint_index_map u_map (
        .n (rd_n),
        .k (rcnt_q),
        .i (rd_idx)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wsel_d  = wsel_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        if (wr_en) begin
            if (wsel_q) buf1_d[wr_addr] = in;
            else        buf0_d[wr_addr] = in;
        end
        if (restart) begin
            state_d = SIG;
            wcnt_d  = 7'd1;
        end else if (blk_done) begin
            state_d = DATA;
            wcnt_d  = 7'd0;
            wsel_d  = ~wsel_q;
        end else if (wr_en) begin
            wcnt_d  = wcnt_q + 7'd1;
        end
    end

    always_comb begin
        rd_act_d    = rd_act_q;
        rcnt_d      = rcnt_q;
        rd_sel_d    = rd_sel_q;
        rd_sig_d    = rd_sig_q;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        if (rd_act_q) begin
            out_d       = rd_bit;
            out_valid_d = 1'b1;
            rcnt_d      = rcnt_q + 7'd1;
            if (rcnt_q == (rd_n - 7'd1)) rd_act_d = 1'b0;
        end
        // A new block taking over on the old drain's last edge gives back-to-back output.
        if (blk_done) begin
            rd_act_d = 1'b1;
            rcnt_d   = 7'd0;
            rd_sel_d = wsel_q;
            rd_sig_d = (state_q == SIG);
        end
        if (restart) begin
            rd_act_d    = 1'b0;
            out_d       = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wcnt_q      <= 7'd0;
            wsel_q      <= 1'b0;
            rd_act_q    <= 1'b0;
            rcnt_q      <= 7'd0;
            rd_sel_q    <= 1'b0;
            rd_sig_q    <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            wsel_q      <= wsel_d;
            rd_act_q    <= rd_act_d;
            rcnt_q      <= rcnt_d;
            rd_sel_q    <= rd_sel_d;
            rd_sig_q    <= rd_sig_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

`ifdef DEINT_BLOCK_FLAGS_EN
    logic out_sob_q, out_sob_d;
    logic out_sig_q, out_sig_d;

    always_comb begin
        out_sob_d = out_valid_d & (rcnt_q == 7'd0);
        out_sig_d = out_valid_d & rd_sig_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_sob_q <= 1'b0;
            out_sig_q <= 1'b0;
        end else begin
            out_sob_q <= out_sob_d;
            out_sig_q <= out_sig_d;
        end
    end

    assign out_sob = out_sob_q;
    assign out_sig = out_sig_q;
`endif

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for the deinterleaver: latency, permutation, back-to-back drain, gaps, reset and sof abort.
module tb_deinterleaver;

    logic clk = 1'b0;
    logic reset, din, in_valid, sof;
    logic out, out_valid;
`ifdef DEINT_BLOCK_FLAGS_EN
    logic out_sob, out_sig;
    int   sob_cnt = 0, sig_cnt = 0, flag_bad = 0;
`endif

    int total = 0, bad = 0;
    int cyc = 0, last_edge = 0, zero_bad = 0, run = 0;
    logic prev_v = 1'b0;
    logic obits[$];
    int   bstart[$];
    int   blen[$];

    deinterleaver dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .in_valid  (in_valid),
        .sof       (sof),
        .out       (out),
        .out_valid (out_valid)
`ifdef DEINT_BLOCK_FLAGS_EN
        ,
        .out_sob   (out_sob),
        .out_sig   (out_sig)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (!prev_v) begin
                bstart.push_back(cyc);
                run = 0;
            end
            obits.push_back(out);
            run = run + 1;
        end else begin
            if (prev_v) blen.push_back(run);
            if (out !== 1'b0) zero_bad = zero_bad + 1;
        end
        prev_v = (out_valid === 1'b1);
`ifdef DEINT_BLOCK_FLAGS_EN
        if (out_sob === 1'b1) sob_cnt = sob_cnt + 1;
        if (out_sig === 1'b1) sig_cnt = sig_cnt + 1;
        if ((out_sob === 1'b1 || out_sig === 1'b1) && out_valid !== 1'b1) flag_bad = flag_bad + 1;
`endif
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        obits.delete();
        bstart.delete();
        blen.delete();
`ifdef DEINT_BLOCK_FLAGS_EN
        sob_cnt = 0;
        sig_cnt = 0;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        @(negedge clk);
        din = b; sof = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        last_edge = cyc;
        din = 1'b0; sof = 1'b0; in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [95:0] v, input int n, input logic with_sof, input logic gaps);
        for (int j = 0; j < n; j++) begin
            if (gaps && $urandom_range(1, 0) == 1) idle(1);
            send_bit(v[j], with_sof && (j == 0));
        end
    endtask

    task automatic get_bits(input int n, output logic [95:0] v);
        v = '0;
        for (int k = 0; k < n; k++)
            if (obits.size() > 0) v[k] = obits.pop_front();
    endtask

    // Reference inverse permutation: output k takes written bit (n/16)*(k%16)+k/16.
    function automatic logic [95:0] deint(input logic [95:0] v, input int n);
        logic [95:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k] = v[(n / 16) * (k % 16) + (k / 16)];
        return r;
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [95:0] v, g, e96, mask;
        logic [95:0] s, d [3];
        int e [4];

        reset = 1'b1; din = 1'b0; in_valid = 1'b0; sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 1'b0);
`ifdef DEINT_BLOCK_FLAGS_EN
        check("rst_flags", {out_sob, out_sig}, 2'b00);
`endif
        reset = 1'b0;
        idle(2);

        // SIGNAL with only j=3 set -> only k=1 set
        clear_mon();
        v = '0; v[3] = 1'b1;
        send_block(v, 48, 1'b1, 1'b0);
        e[0] = last_edge;
        idle(60);
        check("sig_nburst", blen.size(), 1);
        check("sig_len", blen[0], 48);
        check("sig_lat", bstart[0], e[0] + 1);
        check("sig_nbits", obits.size(), 48);
        get_bits(48, g);
        check("sig_bits", g, 96'h2);

        // DATA with only j=7 set -> only k=17
        clear_mon();
        v = '0; v[7] = 1'b1;
        send_block(v, 96, 1'b0, 1'b0);
        e[0] = last_edge;
        idle(110);
        check("d7_len", blen[0], 96);
        check("d7_lat", bstart[0], e[0] + 1);
        get_bits(96, g);
        e96 = '0; e96[17] = 1'b1;
        check("d7_bits", g, e96);

        // DATA with only j=95 set -> only k=95
        clear_mon();
        v = '0; v[95] = 1'b1;
        send_block(v, 96, 1'b0, 1'b0);
        idle(110);
        check("d95_len", blen[0], 96);
        get_bits(96, g);
        e96 = '0; e96[95] = 1'b1;
        check("d95_bits", g, e96);

        // Continuous frame: SIGNAL + 3 DATA, DATA drains back-to-back
        clear_mon();
        s = rnd96();
        for (int b = 0; b < 3; b++) d[b] = rnd96();
        send_block(s, 48, 1'b1, 1'b0);
        e[0] = last_edge;
        for (int b = 0; b < 3; b++) begin
            send_block(d[b], 96, 1'b0, 1'b0);
            e[b + 1] = last_edge;
        end
        idle(110);
        check("cont_nburst", blen.size(), 2);
        check("cont_sig_len", blen[0], 48);
        check("cont_data_len", blen[1], 288);
        check("cont_data_lat", bstart[1], e[1] + 1);
        get_bits(48, g);
        check("cont_sig_bits", g, deint(s, 48));
        for (int b = 0; b < 3; b++) begin
            get_bits(96, g);
            check($sformatf("cont_d%0d_bits", b), g, deint(d[b], 96));
        end
`ifdef DEINT_BLOCK_FLAGS_EN
        check("flag_sob_cnt", sob_cnt, 4);
        check("flag_sig_cnt", sig_cnt, 48);
`endif

        // Gapped DATA input: bursts stay 96 long, latency one edge
        clear_mon();
        s = rnd96(); d[0] = rnd96(); d[1] = rnd96();
        send_block(s, 48, 1'b1, 1'b0);
        send_block(d[0], 96, 1'b0, 1'b1);
        e[1] = last_edge;
        send_block(d[1], 96, 1'b0, 1'b1);
        e[2] = last_edge;
        idle(110);
        check("gap_nburst", blen.size(), 3);
        check("gap_len1", blen[1], 96);
        check("gap_len2", blen[2], 96);
        check("gap_lat1", bstart[1], e[1] + 1);
        check("gap_lat2", bstart[2], e[2] + 1);
        get_bits(48, g);
        check("gap_sig_bits", g, deint(s, 48));
        get_bits(96, g);
        check("gap_d0_bits", g, deint(d[0], 96));
        get_bits(96, g);
        check("gap_d1_bits", g, deint(d[1], 96));

        // Reset mid-drain at DATA j=40
        clear_mon();
        send_block(rnd96(), 48, 1'b1, 1'b0);
        send_block(rnd96(), 96, 1'b0, 1'b0);
        send_block(rnd96(), 40, 1'b0, 1'b0);
        check("pre_rst_draining", out_valid, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 1'b0);
        check("rst_async_out", out, 1'b0);
        idle(2);
        reset = 1'b0;
        idle(1);
        clear_mon();
        for (int j = 0; j < 30; j++) send_bit(1'b1, 1'b0);
        idle(120);
        check("ign_nburst", blen.size(), 0);
        check("ign_nbits", obits.size(), 0);
        v = '0; v[3] = 1'b1;
        send_block(v, 48, 1'b1, 1'b0);
        idle(60);
        check("post_rst_len", blen[0], 48);
        get_bits(48, g);
        check("post_rst_bits", g, 96'h2);

        // sof at DATA j=50 aborts the partial block and the running drain
        clear_mon();
        d[0] = rnd96(); d[1] = rnd96(); s = rnd96();
        send_block(d[0], 96, 1'b0, 1'b0);
        send_block(d[1], 50, 1'b0, 1'b0);
        check("pre_abort_draining", out_valid, 1'b1);
        send_block(s, 48, 1'b1, 1'b0);
        idle(60);
        check("abort_nburst", blen.size(), 2);
        check("abort_drain_len", blen[0], 50);
        check("abort_sig_len", blen[1], 48);
        mask = '0;
        for (int k = 0; k < 50; k++) mask[k] = 1'b1;
        get_bits(50, g);
        check("abort_drain_bits", g, deint(d[0], 96) & mask);
        get_bits(48, g);
        check("abort_sig_bits", g, deint(s, 48));

        check("idle_out_zero", zero_bad, 0);
`ifdef DEINT_BLOCK_FLAGS_EN
        check("flag_only_valid", flag_bad, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
